// File: rtl/uart_fifo_bridge_if.sv
// uart_fifo_bridge_if -- groups the bridge's Avalon-MM master bus toward the
// UART and its TX/RX character streams.
//   modport master : the bridge side (drives avm_read/avm_write/avm_writedata,
//                    tx_ready, rx_valid/rx_data/rx_perr, rx_ovf, levels)
//   modport slave  : the environment side (UART slave and stream endpoints)
// Parameters must match those of the bridge instance attached to it.
interface uart_fifo_bridge_if #(
  parameter int BYTESIZE = 8,
  parameter int ADW      = 32,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
);
  localparam int TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int RX_LW = $clog2(RX_DEPTH) + 1;

  // Avalon-MM master toward the UART
  logic                avm_read;
  logic                avm_write;
  logic [ADW-1:0]      avm_writedata;
  logic [ADW-1:0]      avm_readdata;
  logic                avm_waitrequest;
  logic                avm_interrupt;

  // TX character stream (into the bridge)
  logic                tx_valid;
  logic                tx_ready;
  logic [BYTESIZE-1:0] tx_data;

  // RX character stream (out of the bridge)
  logic                rx_valid;
  logic                rx_ready;
  logic [BYTESIZE-1:0] rx_data;
  logic                rx_perr;
  logic                rx_ovf;

  // FIFO occupancy
  logic [TX_LW-1:0]    tx_level;
  logic [RX_LW-1:0]    rx_level;

  modport master (
    output avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_interrupt,
    input  tx_valid, tx_data,
    output tx_ready,
    output rx_valid, rx_data, rx_perr, rx_ovf,
    input  rx_ready,
    output tx_level, rx_level
  );

  modport slave (
    input  avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_interrupt,
    output tx_valid, tx_data,
    input  tx_ready,
    input  rx_valid, rx_data, rx_perr, rx_ovf,
    output rx_ready,
    input  tx_level, rx_level
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge -- decouples a polled Avalon-MM UART from two character
// streams. A TX FIFO buffers characters to be written to the UART, an RX FIFO
// collects characters (plus their parity-error flag) read from it. A three-state
// controller (IDLE/READ/WRITE) performs one Avalon transfer at a time, reads
// taking priority whenever the UART interrupts and the RX FIFO has room.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : uart_fifo_bridge_if.master (Avalon master, TX/RX streams, levels)
module uart_fifo_bridge #(
  parameter int    BYTESIZE = 8,
  parameter string PARITY   = "NONE",
  parameter int    ADW      = 32,
  parameter int    TX_DEPTH = 16,
  parameter int    RX_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  uart_fifo_bridge_if.master  bus
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_LW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_LW = RX_AW + 1;
  localparam bit HAS_PARITY = (PARITY != "NONE");

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  // ---------------------------------------------------------------- TX FIFO
  logic [BYTESIZE-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]    tx_wr_ptr;
  logic [TX_AW-1:0]    tx_rd_ptr;
  logic [TX_LW-1:0]    tx_cnt;
  logic                tx_full;
  logic                tx_empty;
  logic                tx_push;
  logic                tx_pop;

  assign tx_full  = (tx_cnt == TX_LW'(TX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  // tx_ready comes straight from the registered count, so a pop in the same
  // cycle does not open the door to a push into a full FIFO.
  assign tx_push  = bus.tx_valid && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  // Each entry is {parity_error, data}.
  logic [BYTESIZE:0]   rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]    rx_wr_ptr;
  logic [RX_AW-1:0]    rx_rd_ptr;
  logic [RX_LW-1:0]    rx_cnt;
  logic                rx_full;
  logic                rx_empty;
  logic                rx_push;
  logic                rx_pop;
  logic                rd_perr;
  logic [BYTESIZE:0]   rx_head;

  assign rx_full  = (rx_cnt == RX_LW'(RX_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = !rx_empty && bus.rx_ready;
  assign rd_perr  = HAS_PARITY ? bus.avm_readdata[ADW-3] : 1'b0;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= {rd_perr, bus.avm_readdata[BYTESIZE-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  assign rx_head = rx_mem[rx_rd_ptr];

  // ------------------------------------------------------------ controller
  logic [1:0]     state;
  logic [ADW-1:0] wdata;
  logic           ovf;

  // A transfer completes in the cycle waitrequest is low. Every completion
  // returns to IDLE, which gives the UART one cycle to drop its interrupt
  // before the next decision, so one character is never read twice.
  assign tx_pop  = (state == WRITE) && !bus.avm_waitrequest;
  assign rx_push = (state == READ) && !bus.avm_waitrequest
                   && bus.avm_readdata[ADW-1] && !rx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wdata <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.avm_interrupt && !rx_full) begin
            state <= READ;
          end else if (!tx_empty) begin
            state <= WRITE;
            // Latched once on entry so the word stays stable while stalled.
            wdata <= ADW'(tx_mem[tx_rd_ptr]);
          end
        end
        READ: begin
          if (!bus.avm_waitrequest) begin
            state <= IDLE;
            if (bus.avm_readdata[ADW-2]) ovf <= 1'b1;
          end
        end
        WRITE: begin
          if (!bus.avm_waitrequest) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the state register only, so they are glitch-free and
  // mutually exclusive by construction.
  assign bus.avm_read      = (state == READ);
  assign bus.avm_write     = (state == WRITE);
  assign bus.avm_writedata = wdata;

  assign bus.tx_ready = !tx_full;
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_data  = rx_head[BYTESIZE-1:0];
  assign bus.rx_perr  = rx_head[BYTESIZE];
  assign bus.rx_ovf   = ovf;
  assign bus.tx_level = tx_cnt;
  assign bus.rx_level = rx_cnt;

  // Status bits between the flags and the character are don't-care.
  logic unused_rdata;
  assign unused_rdata = ^bus.avm_readdata;
endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameters: BYTESIZE, default 8, UART character width; PARITY, default "NONE", "EVEN"/"ODD"/"NONE" matching the attached UART; ADW, default 32, Avalon data width; TX_DEPTH, default 16, TX FIFO entries (power of 2); RX_DEPTH, default 16, RX FIFO entries (power of 2).
REQ-002 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have avm_read  output  1  Avalon master read to the UART slave.
REQ-005 SHALL have avm_write  output  1  Avalon master write to the UART slave.
REQ-006 SHALL have avm_writedata  output  ADW  TX character in bits [BYTESIZE-1:0]; upper bits 0.
REQ-007 SHALL have avm_readdata  input  ADW  UART status word: [ADW-1]=ready, [ADW-2]=overrun error, [ADW-3]=parity error (PARITY!="NONE" only), [BYTESIZE-1:0]=data.
REQ-008 SHALL have avm_waitrequest  input  1  UART busy; transfer accepted in the cycle it is low.
REQ-009 SHALL have avm_interrupt  input  1  UART receive-ready or error.
REQ-010 SHALL have tx_valid, tx_ready  input/output  1 each  TX stream handshake.
REQ-011 SHALL have tx_data  input  BYTESIZE  TX character.
REQ-012 SHALL have rx_valid, rx_ready  output/input  1 each  RX stream handshake.
REQ-013 SHALL have rx_data  output  BYTESIZE  RX character at FIFO head.
REQ-014 SHALL have rx_perr  output  1  parity error flag of RX FIFO head (0 when PARITY="NONE").
REQ-015 SHALL have rx_ovf  output  1  sticky UART overrun seen; cleared by reset only.
REQ-016 SHALL have tx_level, rx_level  output  $clog2(DEPTH)+1 each  FIFO occupancy.

Function
REQ-017 SHALL contain a TX FIFO (BYTESIZE wide) and an RX FIFO (BYTESIZE+1 wide: data, parity error).
REQ-018 tx_ready SHALL equal TX not full; push on tx_valid & tx_ready.
REQ-019 rx_valid SHALL equal RX not empty; pop on rx_valid & rx_ready; rx_data/rx_perr show head combinationally from storage.
REQ-020 Simultaneous push and pop on one FIFO SHALL keep level unchanged, including when full (TX: pop frees slot, push still gated by registered tx_ready) or empty (RX: pop gated by rx_valid).
REQ-021 Pointers SHALL wrap modulo DEPTH; level SHALL reach exactly DEPTH when full.
REQ-022 SHALL implement FSM states IDLE, READ, WRITE.
REQ-023 IDLE -> READ when avm_interrupt=1 and RX not full (read has priority).
REQ-024 IDLE -> WRITE when READ condition false and TX not empty.
REQ-025 READ: avm_read=1 held until avm_waitrequest=0; in that cycle capture avm_readdata, then -> IDLE.
REQ-026 On captured read: if ready bit=1, push {parity bit, data} to RX FIFO; if error bit=1, set rx_ovf.
REQ-027 WRITE: avm_write=1, avm_writedata = TX FIFO head, held stable until avm_waitrequest=0; then pop TX and -> IDLE.
REQ-028 avm_read and avm_write SHALL never be asserted together; both SHALL be registered (decoded from state).
REQ-029 Every transfer SHALL be followed by at least one IDLE cycle so the UART status clear is visible before the next decision; no duplicate read of one character.
REQ-030 With interrupt high and RX full, SHALL not read; WRITEs continue; reading resumes once RX has space.
REQ-031 Latency: UART ready to RX FIFO push SHALL be ≤3 cycles when idle and RX not full.

Reset
REQ-032 While rst=1: state IDLE, avm_read=0, avm_write=0, avm_writedata=0, both FIFOs empty (tx_ready=1, rx_valid=0, levels 0), rx_ovf=0.
REQ-033 Reset during READ or WRITE SHALL abort the transfer the next cycle; pending TX character discarded.

Verification
REQ-034 Push 0x55, 0xA3 on TX, waitrequest low -> two WRITE transfers, avm_writedata 0x55 then 0xA3, ≥1 idle cycle between.
REQ-035 WRITE with waitrequest high 10 cycles -> avm_write and data 0xA3 stable 11 cycles, single pop.
REQ-036 Interrupt with readdata 0x8000_003C -> one read, rx_data=0x3C, rx_perr=0, rx_level=1, rx_ovf=0.
REQ-037 Readdata 0xC000_0011 -> 0x11 pushed, rx_ovf=1 and stays 1 after further reads.
REQ-038 Fill RX to 16 with rx_ready=0, interrupt held -> no avm_read while full, TX writes still occur; pop one -> read resumes.
REQ-039 Interrupt and TX non-empty in same IDLE cycle -> READ first, WRITE next; rst mid-WRITE -> avm_write=0 next cycle, levels 0.
